// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types, word width and byte-lane merge helper for the SRAM responder
package sram_pkg;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_WR
  } resp_state_t;

  localparam int WORD_W = 16;

  // Replace only the byte lanes whose active-low enable is asserted
  function automatic logic [WORD_W-1:0] byte_merge(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] new_word,
    input logic              ub_n,
    input logic              lb_n
  );
    logic [WORD_W-1:0] merged;
    merged = old_word;
    if (!ub_n) merged[15:8] = new_word[15:8];
    if (!lb_n) merged[7:0]  = new_word[7:0];
    return merged;
  endfunction

endpackage

// File: rtl/sram_responder_if.sv
// rtl/sram_responder_if.sv - CPU-side active-low SRAM strobe bus with master/slave views
interface sram_responder_if
  import sram_pkg::*;
#(
  parameter int ADDR_W = 20
);

  logic              Mem_CE;
  logic              Mem_UB;
  logic              Mem_LB;
  logic              Mem_OE;
  logic              Mem_WE;
  logic [ADDR_W-1:0] ADDR;
  logic [WORD_W-1:0] Data_from_CPU;
  logic [WORD_W-1:0] Data_to_CPU;

  modport master (
    output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_from_CPU,
    input  Data_to_CPU
  );

  modport slave (
    input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_from_CPU,
    output Data_to_CPU
  );

endinterface

// File: rtl/sram_word_array.sv
// rtl/sram_word_array.sv - DEPTH x 16 word store, clocked byte-lane writes, combinational read
module sram_word_array
  import sram_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              we_hi,
  input  logic              we_lo,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Each byte lane has its own enable so partial stores leave the other lane intact
  always_ff @(posedge Clk) begin
    if (we_hi) mem[waddr][15:8] <= wdata[15:8];
    if (we_lo) mem[waddr][7:0]  <= wdata[7:0];
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - strobe-driven SRAM stand-in with post-reset clear, I/O word and bus error
module sram_responder
  import sram_pkg::*;
#(
  parameter int                ADDR_W  = 20,
  parameter int                DEPTH   = 256,
  parameter logic [ADDR_W-1:0] IO_ADDR = 20'hFFFFF
) (
  input  logic              Clk,
  input  logic              Reset,
  sram_responder_if.slave   bus,
  input  logic [WORD_W-1:0] Switches,
  output logic [WORD_W-1:0] Hex_out,
  output logic              Ready,
  output logic              Bus_err
);

  localparam int AW = $clog2(DEPTH);

  resp_state_t       state, state_next;
  logic [AW-1:0]     cnt;
  logic [ADDR_W-1:0] pend_addr;
  logic [WORD_W-1:0] pend_data;
  logic              pend_ub, pend_lb;
  logic [WORD_W-1:0] data_q;

  logic rd, wr;
  logic init_wr, do_read, do_capture, do_commit;
  logic rd_io, rd_in, pend_io, pend_in;

  logic              arr_we_hi, arr_we_lo;
  logic [AW-1:0]     arr_waddr;
  logic [WORD_W-1:0] arr_wdata, arr_rdata, rd_word, rd_next;

  assign rd = ~bus.Mem_CE & ~bus.Mem_OE & bus.Mem_WE;
  assign wr = ~bus.Mem_CE & ~bus.Mem_WE;

  assign rd_io   = (bus.ADDR == IO_ADDR);
  assign rd_in   = (bus.ADDR[ADDR_W-1:AW] == '0);
  assign pend_io = (pend_addr == IO_ADDR);
  assign pend_in = (pend_addr[ADDR_W-1:AW] == '0);

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_INIT;
    else       state <= state_next;
  end

  // Next state: clear sweep, then wait for a store, commit on WE release or drop on CE release
  always_comb begin
    state_next = state;
    case (state)
      S_INIT:  if (cnt == AW'(DEPTH - 1)) state_next = S_IDLE;
      S_IDLE:  if (wr) state_next = S_WR;
      S_WR:    if (bus.Mem_CE || bus.Mem_WE) state_next = S_IDLE;
      default: state_next = S_INIT;
    endcase
  end

  // Per-state actions; reads are also serviced in the commit cycle so same-cycle readback works
  always_comb begin
    init_wr    = 1'b0;
    do_read    = 1'b0;
    do_capture = 1'b0;
    do_commit  = 1'b0;
    Ready      = 1'b0;
    case (state)
      S_INIT: init_wr = 1'b1;
      S_IDLE: begin
        Ready      = 1'b1;
        do_read    = rd;
        do_capture = wr;
      end
      S_WR: begin
        Ready      = 1'b1;
        do_read    = rd;
        do_capture = wr;
        do_commit  = ~bus.Mem_CE & bus.Mem_WE;
      end
      default: ;
    endcase
  end

  // The clear sweep and committed stores share the array's single write port
  assign arr_we_hi = ~Reset & (init_wr | (do_commit & pend_in & ~pend_ub));
  assign arr_we_lo = ~Reset & (init_wr | (do_commit & pend_in & ~pend_lb));
  assign arr_waddr = init_wr ? cnt : pend_addr[AW-1:0];
  assign arr_wdata = init_wr ? '0 : pend_data;

  sram_word_array #(.DEPTH(DEPTH)) u_array (
    .Clk   (Clk),
    .we_hi (arr_we_hi),
    .we_lo (arr_we_lo),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (bus.ADDR[AW-1:0]),
    .rdata (arr_rdata)
  );

  // Read source select, forwarding a store that commits in the same cycle
  always_comb begin
    rd_word = arr_rdata;
    if (do_commit && (pend_addr == bus.ADDR))
      rd_word = byte_merge(arr_rdata, pend_data, pend_ub, pend_lb);
    if (rd_io)      rd_next = Switches;
    else if (rd_in) rd_next = rd_word;
    else            rd_next = '0;
  end

  // Clear counter, pending store, read data, hex register and bus-error pulse
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt       <= '0;
      pend_addr <= '0;
      pend_data <= '0;
      pend_ub   <= 1'b0;
      pend_lb   <= 1'b0;
      data_q    <= '0;
      Hex_out   <= '0;
      Bus_err   <= 1'b0;
    end else begin
      if (init_wr) cnt <= cnt + AW'(1);
      if (do_capture) begin
        pend_addr <= bus.ADDR;
        pend_data <= bus.Data_from_CPU;
        pend_ub   <= bus.Mem_UB;
        pend_lb   <= bus.Mem_LB;
      end
      if (do_read) data_q <= rd_next;
      if (do_commit && pend_io) Hex_out <= byte_merge(Hex_out, pend_data, pend_ub, pend_lb);
      Bus_err <= (do_read & ~rd_io & ~rd_in) | (do_commit & ~pend_io & ~pend_in);
    end
  end

  assign bus.Data_to_CPU = data_q;

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Memory-side responder for the SLC-3 datapath's active-low asynchronous-SRAM-style strobe interface (Mem_CE/OE/WE/UB/LB).
- Sits between the CPU top level and an on-chip word array; replaces the physical SRAM during simulation and FPGA bring-up.
- Serves the control FSM's fixed multi-cycle fetch, load and store sequences.
- Memory-maps a switch input and a hex-display register at one I/O address, and runs a post-reset clear sequence.

Parameters:
ADDR_W, 20, width of ADDR bus
DEPTH, 256, number of 16-bit words backed by the array (power of 2, at most 2^ADDR_W - 1)
IO_ADDR, 20'hFFFFF, the I/O address: reads return Switches, writes update Hex_out

Ports:
Clk  in  1  clock
Reset  in  1  synchronous, active-high
Mem_CE  in  1  chip enable, active low
Mem_UB  in  1  upper-byte enable, active low
Mem_LB  in  1  lower-byte enable, active low
Mem_OE  in  1  output enable, active low
Mem_WE  in  1  write enable, active low
ADDR  in  ADDR_W  word address (MAR)
Data_from_CPU  in  16  write data (MDR)
Data_to_CPU  out  16  registered read data
Switches  in  16  value returned on reads of IO_ADDR
Hex_out  out  16  last value written to IO_ADDR
Ready  out  1  high once the clear sequence completes
Bus_err  out  1  one-cycle pulse on an out-of-range access

Behaviour:
- Clock and reset: Clk is the clock. Reset is synchronous, active-high.
- Reset values: Data_to_CPU=0, Hex_out=0, Ready=0, Bus_err=0, state=S_INIT, clear counter=0, pending-write registers=0.
- Definitions: rd = ~Mem_CE & ~Mem_OE & Mem_WE; wr = ~Mem_CE & ~Mem_WE.
- S_INIT:
  - Writes 16'h0000 to word[cnt] each cycle, cnt = 0..DEPTH-1.
  - Moves to S_IDLE after the write to word DEPTH-1, so the clear takes exactly DEPTH cycles.
  - Ready rises in the first S_IDLE cycle.
  - All strobes are ignored; Data_to_CPU holds 0.
- Read, S_IDLE, 1-cycle latency:
  - If rd is high in cycle N, Data_to_CPU at edge N+1 becomes word[ADDR], or Switches if ADDR==IO_ADDR.
  - Data_to_CPU then holds until the next rd cycle. This lets the CPU drop OE and still latch MDR one cycle later.
  - UB/LB are ignored on reads (the full word is returned).
- Write entry: wr high in S_IDLE -> go to S_WR. Every wr cycle captures ADDR, Data_from_CPU, UB and LB into the pending registers, so the last low cycle wins.
- Write commit, S_WR:
  - On the first cycle with Mem_WE=1 and Mem_CE=0, commit the pending write and return to S_IDLE.
  - Committed data lands at the edge ending that cycle; a read of the same address in that same cycle returns the new data.
  - Byte lanes: bits 15:8 are written only if pending UB=0; bits 7:0 only if pending LB=0. Both high -> nothing written.
  - Pending address == IO_ADDR -> Hex_out is updated with the same byte-lane rules; the array is untouched.
- Abort: Mem_CE=1 while in S_WR discards the pending write and returns to S_IDLE.
- OE and WE both low: wr takes priority; no read is performed and Data_to_CPU holds.
- Out of range: address >= DEPTH and != IO_ADDR.
  - Read: returns 16'h0000.
  - Write: dropped at commit.
  - Either way, Bus_err pulses for exactly 1 cycle (on the edge after the rd cycle, or on the commit edge).
- Reset mid-write: pending write discarded, state -> S_INIT, and the clear re-runs in full.

Decomposition:
- Package sram_pkg holds:
  - enum resp_state_t {S_INIT, S_IDLE, S_WR};
  - localparam WORD_W=16;
  - a function byte_merge(old, new, ub_n, lb_n).
- One sub-module: sram_word_array, a single-port synchronous-write, asynchronous-read DEPTH x 16 array with per-byte write enables.
- The responder holds the FSM, the pending-write registers, the I/O decode and Bus_err.

Test Plan:
- Reset, then idle for DEPTH+2 cycles -> Ready is 0 for exactly DEPTH cycles then 1; a read of addr 5 returns 16'h0000.
- Write 16'h1234 to addr 3 using the store sequence:
  - the sequence is one WE-low cycle with data 16'hXXXX, one WE-low cycle with 16'h1234, then WE high;
  - a read of 3 (OE low for 1 cycle) gives Data_to_CPU=16'h1234 on the next edge, held after OE rises.
- Byte lanes: word 7 = 16'hAAAA; write 16'h5555 with UB=1, LB=0 -> reads 16'hAA55. Write 16'h1111 with UB=LB=1 -> still 16'hAA55.
- I/O: Switches=16'hBEEF; read IO_ADDR -> 16'hBEEF. Write 16'h0C0C to IO_ADDR -> Hex_out=16'h0C0C, array word unchanged.
- Out of range and abort:
  - read addr 300 -> 16'h0000 and Bus_err pulses 1 cycle;
  - WE low to addr 4, then CE=1 before WE rises -> word 4 unchanged, no Bus_err.
- Reset mid-write: WE low to addr 2 with 16'hFFFF, assert Reset -> Ready drops; after DEPTH cycles word 2 = 16'h0000.
